gpu_command_decoder: RTL and testbench



---
 rtl/gpu_command_decoder.sv | 180 ++++++++++++++++++
 tb/tb_gpu_command_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_command_decoder.sv
// gpu_command_decoder: queues commands from the command buffer and dispatches register writes, VRAM reads and render/soft-reset ops.
// Optional macro GPU_CMD_DROP_COUNT_EN enables the saturating dropped-command counter on droppedCount.
`default_nettype none

module gpu_command_decoder #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          READ_TIMEOUT = 255,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic        pipelineClock,
  input  logic        reset,
  input  logic [15:0] gpuCommand,
  input  logic [15:0] gpuData,
  input  logic        renderDone,
  input  logic        memRdAck,
  input  logic [15:0] memRdData,
  output logic        gpuBusy,
  output logic        renderStart,
  output logic        regSoftReset,
  output logic        regWrEn,
  output logic [13:0] regWrAddr,
  output logic [15:0] regWrData,
  output logic        memRdReq,
  output logic [13:0] memRdAddr,
  output logic        readValid,
  output logic [15:0] readData,
  output logic        overflow,
  output logic [7:0]  droppedCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT) : 1;
  localparam logic [AW:0]   c_depth = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] c_tlast = TW'(READ_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ_WAIT, S_READ_RET} state_t;

  state_t        r_state;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [15:0] w_head_cmd;
  logic [15:0] w_head_data;
  logic        w_empty;
  logic        w_full;
  logic        w_push_req;
  logic        w_push;
  logic        w_drop;
  logic        w_pop;
  logic        w_start;

  assign w_head_cmd  = r_mem[r_rd_ptr][31:16];
  assign w_head_data = r_mem[r_rd_ptr][15:0];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_depth);
  assign w_push_req  = (gpuCommand[15:14] != 2'b00);
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;
  assign w_start     = w_pop && (w_head_cmd[15:12] == 4'b1100);

  // Strict in-order issue: a held WRITE/SPECIAL also blocks any READ behind it.
  always_comb begin
    w_pop = 1'b0;
    if (r_state == S_IDLE && !w_empty) begin
      unique case (w_head_cmd[15:14])
        2'b01:        w_pop = 1'b1;
        2'b10, 2'b11: w_pop = !gpuBusy;
        default:      w_pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge pipelineClock) begin
    if (w_push) r_mem[r_wr_ptr] <= {gpuCommand, gpuData};
  end

  always_ff @(posedge pipelineClock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_drop) overflow <= 1'b1;
    end
  end

`ifdef GPU_CMD_DROP_COUNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge pipelineClock or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && r_drop_cnt != 8'hFF) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign droppedCount = r_drop_cnt;
`else
  assign droppedCount = 8'd0;
`endif

  always_ff @(posedge pipelineClock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_tcnt       <= '0;
      gpuBusy      <= 1'b0;
      renderStart  <= 1'b0;
      regSoftReset <= 1'b0;
      regWrEn      <= 1'b0;
      regWrAddr    <= '0;
      regWrData    <= '0;
      memRdReq     <= 1'b0;
      memRdAddr    <= '0;
      readValid    <= 1'b0;
      readData     <= '0;
    end else begin
      renderStart  <= 1'b0;
      regSoftReset <= 1'b0;
      regWrEn      <= 1'b0;
      readValid    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            unique case (w_head_cmd[15:14])
              2'b01: begin
                memRdReq  <= 1'b1;
                memRdAddr <= w_head_cmd[13:0];
                r_tcnt    <= '0;
                r_state   <= S_READ_WAIT;
              end
              2'b10: begin
                regWrEn   <= 1'b1;
                regWrAddr <= w_head_cmd[13:0];
                regWrData <= w_head_data;
              end
              default: begin
                renderStart  <= w_start;
                regSoftReset <= (w_head_cmd[13:12] == 2'b01);
              end
            endcase
          end
        end
        S_READ_WAIT: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (memRdAck) begin
            readData <= memRdData;
            memRdReq <= 1'b0;
            r_state  <= S_READ_RET;
          end else if (r_tcnt == c_tlast) begin
            readData <= TIMEOUT_DATA;
            memRdReq <= 1'b0;
            r_state  <= S_READ_RET;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_READ_RET: begin
          readValid <= 1'b1;
          r_tcnt    <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_start)         gpuBusy <= 1'b1;
      else if (renderDone) gpuBusy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpu_command_decoder.sv
// tb_gpu_command_decoder: directed table-driven vectors plus multi-cycle sequences for gpu_command_decoder.
`default_nettype none

module tb_gpu_command_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0;
  logic [15:0] data = 16'h0;
  logic        rdone = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] mdata = 16'h0;

  logic        gpuBusy, renderStart, regSoftReset, regWrEn, memRdReq, readValid, overflow;
  logic [13:0] regWrAddr, memRdAddr;
  logic [15:0] regWrData, readData;
  logic [7:0]  droppedCount;

  gpu_command_decoder dut (
    .pipelineClock(clk),
    .reset(rst_n),
    .gpuCommand(cmd),
    .gpuData(data),
    .renderDone(rdone),
    .memRdAck(ack),
    .memRdData(mdata),
    .gpuBusy(gpuBusy),
    .renderStart(renderStart),
    .regSoftReset(regSoftReset),
    .regWrEn(regWrEn),
    .regWrAddr(regWrAddr),
    .regWrData(regWrData),
    .memRdReq(memRdReq),
    .memRdAddr(memRdAddr),
    .readValid(readValid),
    .readData(readData),
    .overflow(overflow),
    .droppedCount(droppedCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] data;
    logic        wr;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic        sr;
  } vec_t;

  vec_t vt[5];

`ifdef GPU_CMD_DROP_COUNT_EN
  localparam logic [7:0] EXP_DROP = 8'd2;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  initial begin
    int n;
    int nw;
    int bad;
    int nsr;
    logic [13:0] wa[8];
    logic [15:0] wd[8];

    vt[0] = '{16'h8012, 16'h00AB, 1'b1, 14'h0012, 16'h00AB, 1'b0};
    vt[1] = '{16'hBFFF, 16'h5A5A, 1'b1, 14'h3FFF, 16'h5A5A, 1'b0};
    vt[2] = '{16'h8000, 16'hFFFF, 1'b1, 14'h0000, 16'hFFFF, 1'b0};
    vt[3] = '{16'hD000, 16'h1111, 1'b0, 14'h0000, 16'h0000, 1'b1};
    vt[4] = '{16'hF123, 16'h2222, 1'b0, 14'h0000, 16'h0000, 1'b0};

    // Reset state
    tick(); tick();
    chk("reset_strobes", {renderStart, regSoftReset, regWrEn, memRdReq, readValid, gpuBusy, overflow}, 0);
    chk("reset_buses", {regWrAddr, regWrData}, 0);
    chk("reset_rd", {memRdAddr, readData, droppedCount}, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven single commands with gpuBusy=0
    for (int i = 0; i < 5; i++) begin
      cmd = vt[i].cmd; data = vt[i].data;
      tick();
      cmd = 16'h0; data = 16'h0;
      tick();
      chk($sformatf("v%0d_wren", i), regWrEn, vt[i].wr);
      chk($sformatf("v%0d_softrst", i), regSoftReset, vt[i].sr);
      chk($sformatf("v%0d_other", i), {renderStart, memRdReq, readValid, gpuBusy}, 0);
      if (vt[i].wr) begin
        chk($sformatf("v%0d_addr", i), regWrAddr, vt[i].addr);
        chk($sformatf("v%0d_data", i), regWrData, vt[i].wdata);
      end
      tick();
      chk($sformatf("v%0d_pulse_end", i), {regWrEn, regSoftReset, renderStart}, 0);
    end

    // Render start holds WRITE and the READ queued behind it
    cmd = 16'hC000; tick();
    cmd = 16'h8001; data = 16'h0077; tick();
    chk("rs_pulse", renderStart, 1);
    chk("rs_busy", gpuBusy, 1);
    cmd = 16'h4005; data = 16'h0; tick();
    chk("rs_pulse_end", renderStart, 0);
    cmd = 16'h0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (regWrEn || memRdReq || readValid) bad++;
    end
    chk("held_no_issue", bad, 0);
    chk("held_busy", gpuBusy, 1);
    rdone = 1'b1; tick(); rdone = 1'b0;
    chk("done_busy_clr", gpuBusy, 0);
    tick();
    chk("held_wr_en", regWrEn, 1);
    chk("held_wr_addr", {regWrAddr, regWrData}, {14'h0001, 16'h0077});
    tick();
    chk("rd_req", {memRdReq, memRdAddr}, {1'b1, 14'h0005});
    tick();
    chk("rd_req_hold1", memRdReq, 1);
    tick();
    chk("rd_req_hold2", memRdReq, 1);
    ack = 1'b1; mdata = 16'h1234;
    tick();
    ack = 1'b0; mdata = 16'h0;
    chk("rd_ack_drop", {memRdReq, readValid}, 0);
    tick();
    chk("rd_valid", {readValid, readData}, {1'b1, 16'h1234});
    tick();
    chk("rd_valid_end", readValid, 0);

    // Read timeout
    cmd = 16'h4003; tick();
    cmd = 16'h0; tick();
    chk("to_addr", memRdAddr, 14'h0003);
    n = 0;
    while (memRdReq === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 255);
    chk("to_no_early_valid", readValid, 0);
    tick();
    chk("to_valid", {readValid, readData}, {1'b1, 16'hDEAD});
    tick();

    // Overflow: 6 WRITEs behind a blocked head, then a push on a full-FIFO pop edge
    cmd = 16'hC000; tick();
    for (int k = 0; k < 6; k++) begin
      cmd = 16'h8100 + 16'(k); data = 16'h1000 + 16'(k);
      tick();
      if (k == 3) chk("ovf_not_yet", overflow, 0);
      if (k == 4) chk("ovf_set", overflow, 1);
    end
    cmd = 16'h0; data = 16'h0; rdone = 1'b1;
    tick();
    rdone = 1'b0; cmd = 16'h8107; data = 16'h1007;
    chk("ovf_busy_clr", gpuBusy, 0);
    tick();
    cmd = 16'h0; data = 16'h0;
    nw = 0;
    for (int i = 0; i < 12; i++) begin
      if (regWrEn && nw < 8) begin
        wa[nw] = regWrAddr; wd[nw] = regWrData; nw++;
      end
      tick();
    end
    chk("ovf_writes", nw, 5);
    chk("ovf_first", {wa[0], wd[0]}, {14'h0100, 16'h1000});
    chk("ovf_fourth", {wa[3], wd[3]}, {14'h0103, 16'h1003});
    chk("ovf_fullpop_push", {wa[4], wd[4]}, {14'h0107, 16'h1007});
    chk("ovf_sticky", overflow, 1);
    chk("drop_count", droppedCount, EXP_DROP);

    // Reset during S_READ_WAIT with a WRITE still queued
    cmd = 16'h4003; tick();
    cmd = 16'h8055; data = 16'h0001; tick();
    cmd = 16'h0; data = 16'h0;
    chk("rst_rd_req", memRdReq, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {memRdReq, readValid, regWrEn, gpuBusy, overflow, renderStart, regSoftReset}, 0);
    chk("rst_async_cnt", droppedCount, 0);
    tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (readValid || regWrEn || memRdReq) bad++;
    end
    chk("rst_quiet", bad, 0);

    // SPECIAL soft reset followed by a discarded SPECIAL
    nsr = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      cmd = (i == 0) ? 16'hD000 : ((i == 1) ? 16'hE000 : 16'h0000);
      tick();
      if (regSoftReset) nsr++;
      if (regWrEn || renderStart || memRdReq || readValid || gpuBusy) bad++;
    end
    chk("sp_softrst_once", nsr, 1);
    chk("sp_discard_quiet", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
